cache_refill_ctrl: RTL and testbench
====================================

Name: cache_refill_ctrl

Overview:
Miss-refill engine sitting directly behind the direct-mapped cache. It accepts a miss address from the cache and fetches the whole block from main memory one word at a time, critical word first with wrap-around. It streams each returned word back to the cache's fill port. A pulse marks block completion, and a separate pulse reports a memory timeout.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, word width (4-byte words)
WORDS_PER_BLOCK, 4, words per cache block; power of two, 2..16
TIMEOUT, 64, max cycles to wait for one memory response before aborting

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
miss_valid  in  1  cache presents a miss
miss_addr  in  ADDR_W  byte address of the missing word
miss_ready  out  1  engine idle and able to accept a miss
mem_req_valid  out  1  word read request to memory
mem_req_addr  out  ADDR_W  word-aligned byte address requested
mem_req_ready  in  1  memory accepts the request
mem_rsp_valid  in  1  memory returns one word (in order, one per request)
mem_rsp_data  in  DATA_W  returned word
fill_valid  out  1  fill word valid to cache
fill_addr  out  ADDR_W  word-aligned address of fill word
fill_data  out  DATA_W  fill word
fill_last  out  1  qualifies the final fill word of the block
fill_done  out  1  one-cycle pulse, block refill complete
err_timeout  out  1  one-cycle pulse, refill aborted

Behaviour:
- Reset, sync: while rst=1 at a clk edge, the state goes to IDLE and every output register is cleared. miss_ready=0 during the reset cycle. miss_ready=1 from the first edge after rst falls. Reset mid-refill abandons the block: no fill_done, no err_timeout; late mem_rsp_valid is ignored.
- OFF_W = log2(WORDS_PER_BLOCK). Word index = miss_addr[OFF_W+1:2]. Block base = miss_addr with bits [OFF_W+1:0] cleared. miss_addr[1:0] is ignored.
- States: IDLE, REQ, RESP, DONE.
- IDLE: miss_ready=1. When miss_valid&&miss_ready at edge T, latch the base and start index, clear word counter cnt, and go to REQ. mem_req_valid=1 from T+1.
- REQ: mem_req_valid=1, mem_req_addr = base + ((start+cnt) mod WORDS_PER_BLOCK)*4. The request is held stable until mem_req_ready. On the handshake edge go to RESP and clear the timeout counter.
- RESP: mem_rsp_valid is sampled each cycle.
  - On a response, register fill_valid=1, fill_data=mem_rsp_data and fill_addr = the requested address at the next edge, for exactly one cycle.
  - If cnt=WORDS_PER_BLOCK-1: fill_last=1 with that word, then go to DONE. Otherwise cnt+1 and go to REQ.
  - Timeout counter increments each cycle without a response. When it reaches TIMEOUT-1 with no response: err_timeout pulse for one cycle, go to IDLE, no fill_done.
- DONE: fill_done=1 for one cycle (the cycle after fill_last), then IDLE. miss_ready returns the following cycle.
- Wrap-around: index arithmetic is modulo WORDS_PER_BLOCK and never carries into the tag/index bits.
- mem_rsp_valid outside RESP is ignored. mem_req_ready outside REQ is ignored. miss_valid outside IDLE is not accepted (miss_ready=0) and is not queued.
- Best-case per-block latency with ready=1 and 1-cycle memory response: 2 cycles per word + 2.

Decomposition:
- Shared package cache_pkg:
  - ADDR_W, DATA_W, WORDS_PER_BLOCK, derived OFF_W
  - state enum (IDLE/REQ/RESP/DONE)
  - function block_base(addr)
  - function word_addr(base, idx)
- One natural sub-module: refill_timer, a loadable down-counter with an expire flag, used for the timeout.

Test Plan:
- Aligned miss: miss_addr=0x1FFFFF10, memory ready=1, 1-cycle rsp with data 0xA0..0xA3 -> req addrs 0x1FFFFF10,14,18,1C in order; fill words 0xA0..0xA3 with matching fill_addr; fill_last on 4th; fill_done next cycle; miss_ready back the cycle after.
- Critical-word-first wrap: miss_addr=0x1FFFFF1A -> req order 0x1FFFFF18, 0x1FFFFF1C, 0x1FFFFF10, 0x1FFFFF14; base bits above [3:0] unchanged.
- Backpressure: mem_req_ready low 5 cycles on word 1 -> mem_req_valid/addr held stable 5 cycles; no fill output in that window; block still completes with 4 fills.
- Timeout: no mem_rsp_valid after word 0 request, TIMEOUT=64 -> err_timeout pulses once 64 cycles after the request handshake; no fill_done; miss_ready=1 next cycle; stray later rsp ignored.
- Reset mid-refill: rst=1 after 2 fills -> next cycle all outputs 0; after rst falls, new miss 0x00000040 refills cleanly from word 0.
- Miss during busy: miss_valid held during a refill -> not accepted until miss_ready=1; then accepted exactly once.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types, sizes and address helpers for the cache miss-refill path.
package cache_pkg;

    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned WORDS_PER_BLOCK = 4;
    localparam int unsigned OFF_W           = $clog2(WORDS_PER_BLOCK);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } state_e;

    typedef logic [OFF_W-1:0] idx_t;

    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] mask;
        mask = '1;
        mask = mask << (OFF_W + 2);
        return addr & mask;
    endfunction

    // Replacing only the word-index field keeps wrap-around inside the block.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input idx_t              idx);
        logic [ADDR_W-1:0] a;
        a            = base;
        a[OFF_W+1:2] = idx;
        return a;
    endfunction

endpackage

// File: rtl/refill_timer.sv
// Loadable down-counter; expired is high once the count has run down to zero.
module refill_timer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(TIMEOUT - 1);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/cache_refill_ctrl.sv
// Miss-refill engine: fetches a whole cache block one word at a time, critical
// word first with wrap-around, and streams each returned word to the fill port.
module cache_refill_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_valid,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              miss_ready,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              fill_valid,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic              fill_last,
    output logic              fill_done,
    output logic              err_timeout
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    idx_t              start_q, start_d;
    idx_t              cnt_q, cnt_d;
    logic              miss_ready_q, miss_ready_d;
    logic              mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;
    logic              fill_valid_q, fill_valid_d;
    logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
    logic [DATA_W-1:0] fill_data_q, fill_data_d;
    logic              fill_last_q, fill_last_d;
    logic              fill_done_q, fill_done_d;
    logic              err_timeout_q, err_timeout_d;
    logic              tmr_load, tmr_dec, tmr_expired;

    refill_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .dec    (tmr_dec),
        .expired(tmr_expired)
    );

    always_comb begin
        state_d         = state_q;
        base_d          = base_q;
        start_d         = start_q;
        cnt_d           = cnt_q;
        mem_req_valid_d = 1'b0;
        mem_req_addr_d  = mem_req_addr_q;
        fill_valid_d    = 1'b0;
        fill_addr_d     = '0;
        fill_data_d     = '0;
        fill_last_d     = 1'b0;
        fill_done_d     = 1'b0;
        err_timeout_d   = 1'b0;
        tmr_load        = 1'b0;
        tmr_dec         = 1'b0;

        case (state_q)
            IDLE: begin
                if (miss_valid && miss_ready_q) begin
                    base_d          = block_base(miss_addr);
                    start_d         = miss_addr[OFF_W+1:2];
                    cnt_d           = '0;
                    state_d         = REQ;
                    mem_req_valid_d = 1'b1;
                    mem_req_addr_d  = word_addr(base_d, start_d);
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d  = RESP;
                    tmr_load = 1'b1;
                end else begin
                    mem_req_valid_d = 1'b1;
                end
            end
            RESP: begin
                // A response arriving on the expiry cycle still wins over the abort.
                if (mem_rsp_valid) begin
                    fill_valid_d = 1'b1;
                    fill_addr_d  = mem_req_addr_q;
                    fill_data_d  = mem_rsp_data;
                    if (cnt_q == idx_t'(WORDS_PER_BLOCK - 1)) begin
                        fill_last_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        cnt_d           = cnt_q + idx_t'(1);
                        state_d         = REQ;
                        mem_req_valid_d = 1'b1;
                        mem_req_addr_d  = word_addr(base_q, start_q + cnt_d);
                    end
                end else if (tmr_expired) begin
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            DONE: begin
                fill_done_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Ready only after a full cycle in IDLE, so it trails fill_done / err_timeout.
        miss_ready_d = (state_q == IDLE) && (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            base_q          <= '0;
            start_q         <= '0;
            cnt_q           <= '0;
            miss_ready_q    <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            fill_valid_q    <= 1'b0;
            fill_addr_q     <= '0;
            fill_data_q     <= '0;
            fill_last_q     <= 1'b0;
            fill_done_q     <= 1'b0;
            err_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            base_q          <= base_d;
            start_q         <= start_d;
            cnt_q           <= cnt_d;
            miss_ready_q    <= miss_ready_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            fill_valid_q    <= fill_valid_d;
            fill_addr_q     <= fill_addr_d;
            fill_data_q     <= fill_data_d;
            fill_last_q     <= fill_last_d;
            fill_done_q     <= fill_done_d;
            err_timeout_q   <= err_timeout_d;
        end
    end

    assign miss_ready    = miss_ready_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign fill_valid    = fill_valid_q;
    assign fill_addr     = fill_addr_q;
    assign fill_data     = fill_data_q;
    assign fill_last     = fill_last_q;
    assign fill_done     = fill_done_q;
    assign err_timeout   = err_timeout_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: directed scenarios plus random traffic, all
// outputs checked every cycle against a transaction-level reference model.
module tb_cache_refill_ctrl;

    localparam int W   = 4;
    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_valid;
    logic [31:0] miss_addr;
    logic        miss_ready;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        fill_valid;
    logic [31:0] fill_addr;
    logic [31:0] fill_data;
    logic        fill_last;
    logic        fill_done;
    logic        err_timeout;

    always #5 clk = ~clk;

    cache_refill_ctrl #(
        .TIMEOUT(TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .miss_valid   (miss_valid),
        .miss_addr    (miss_addr),
        .miss_ready   (miss_ready),
        .mem_req_valid(mem_req_valid),
        .mem_req_addr (mem_req_addr),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .fill_valid   (fill_valid),
        .fill_addr    (fill_addr),
        .fill_data    (fill_data),
        .fill_last    (fill_last),
        .fill_done    (fill_done),
        .err_timeout  (err_timeout)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (phase: 0 idle, 1 request, 2 await, 3 finish)
    int          ph = 0, prev_ph = -1, m_k = 0, m_wait = 0;
    logic [31:0] m_addrs [W];
    logic        e_miss_ready = 1'b0, e_req_valid = 1'b0, e_fill_valid = 1'b0;
    logic        e_fill_last = 1'b0, e_done = 1'b0, e_err = 1'b0, e_zero = 1'b0;
    logic [31:0] e_req_addr = '0, e_fill_addr = '0, e_fill_data = '0;
    bit          model_on = 1'b0;

    // observation logs for the directed literal checks
    bit          mem_hs = 1'b0;
    logic [31:0] req_log[$];
    int          hs_cyc[$];
    logic [31:0] stall_addr[$];
    int          acc_cnt = 0;
    logic [31:0] fill_a[$];
    logic [31:0] fill_d[$];
    bit          fill_l[$];
    int          done_cyc[$];

    always @(posedge clk) begin
        int          cur;
        logic [31:0] base;
        int          start;
        cyc++;
        mem_hs = mem_req_valid && mem_req_ready && !rst;
        if (mem_hs) begin
            req_log.push_back(mem_req_addr);
            hs_cyc.push_back(cyc);
        end
        if (mem_req_valid && !mem_req_ready && !rst) stall_addr.push_back(mem_req_addr);
        if (miss_valid && miss_ready && !rst) acc_cnt++;

        e_fill_valid = 1'b0;
        e_fill_last  = 1'b0;
        e_done       = 1'b0;
        e_err        = 1'b0;
        e_zero       = 1'b0;
        if (rst) begin
            ph       = 0;
            prev_ph  = -1;
            e_zero   = 1'b1;
            model_on = 1'b1;
        end else begin
            cur = ph;
            case (cur)
                0: if (miss_valid && e_miss_ready) begin
                    base  = miss_addr & ~32'(W * 4 - 1);
                    start = int'((miss_addr / 4) % W);
                    for (int i = 0; i < W; i++) m_addrs[i] = base + 32'(((start + i) % W) * 4);
                    m_k = 0;
                    ph  = 1;
                end
                1: if (mem_req_ready) begin
                    ph     = 2;
                    m_wait = 0;
                end
                2: if (mem_rsp_valid) begin
                    e_fill_valid = 1'b1;
                    e_fill_addr  = m_addrs[m_k];
                    e_fill_data  = mem_rsp_data;
                    e_fill_last  = (m_k == W - 1);
                    if (m_k == W - 1) ph = 3;
                    else begin
                        m_k++;
                        ph = 1;
                    end
                end else if (m_wait == TMO - 1) begin
                    e_err = 1'b1;
                    ph    = 0;
                end else begin
                    m_wait++;
                end
                default: begin
                    e_done = 1'b1;
                    ph     = 0;
                end
            endcase
            prev_ph = cur;
        end
        e_miss_ready = !rst && ph == 0 && prev_ph == 0;
        e_req_valid  = !rst && ph == 1;
        e_req_addr   = m_addrs[m_k];
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk1("miss_ready", miss_ready, e_miss_ready);
            chk1("mem_req_valid", mem_req_valid, e_req_valid);
            if (e_req_valid) chk32("mem_req_addr", mem_req_addr, e_req_addr);
            chk1("fill_valid", fill_valid, e_fill_valid);
            chk1("fill_last", fill_last, e_fill_last);
            chk1("fill_done", fill_done, e_done);
            chk1("err_timeout", err_timeout, e_err);
            if (e_fill_valid) begin
                chk32("fill_addr", fill_addr, e_fill_addr);
                chk32("fill_data", fill_data, e_fill_data);
            end
            if (e_zero) begin
                chk32("rst_req_addr", mem_req_addr, 32'h0);
                chk32("rst_fill_addr", fill_addr, 32'h0);
                chk32("rst_fill_data", fill_data, 32'h0);
            end
        end
        if (fill_valid) begin
            fill_a.push_back(fill_addr);
            fill_d.push_back(fill_data);
            fill_l.push_back(fill_last);
        end
        if (fill_done) done_cyc.push_back(cyc);
    end

    // ---------------- memory responder
    bit cfg_rand = 1'b0, cfg_seq = 1'b0, cfg_drop = 1'b0;
    int cfg_stall_hs = -1, cfg_stall_len = 0;
    int cd = -1, seq = 0, hs_cnt = 0, stall_left = 0;

    task automatic mem_drive();
        if (mem_hs) begin
            hs_cnt++;
            if (cfg_drop) begin
                cfg_drop = 1'b0;
                cd       = -1;
            end else begin
                cd = cfg_rand ? int'($urandom_range(1, 4)) : 1;
            end
        end
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = $urandom;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = cfg_seq ? 32'(32'hA0 + seq) : $urandom;
                seq++;
                cd = -1;
            end
        end else if (cfg_rand && ph != 2 && $urandom_range(0, 7) == 0) begin
            mem_rsp_valid = 1'b1;
        end
        if (cfg_stall_hs == hs_cnt && mem_req_valid) begin
            stall_left   = cfg_stall_len;
            cfg_stall_hs = -1;
        end
        if (stall_left > 0) begin
            mem_req_ready = 1'b0;
            stall_left--;
        end else begin
            mem_req_ready = cfg_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        mem_drive();
    endtask

    task automatic clear_logs();
        req_log.delete();
        hs_cyc.delete();
        stall_addr.delete();
        fill_a.delete();
        fill_d.delete();
        fill_l.delete();
        done_cyc.delete();
        acc_cnt = 0;
        hs_cnt  = 0;
        seq     = 0;
    endtask

    task automatic do_miss(input logic [31:0] a, input int budget, output int acc_t);
        bit took;
        took       = 1'b0;
        acc_t      = -1;
        miss_valid = 1'b1;
        miss_addr  = a;
        for (int i = 0; i < budget && !took; i++) begin
            took = miss_ready;
            tick();
            if (took) acc_t = cyc;
        end
        miss_valid = 1'b0;
        miss_addr  = $urandom;
        total++;
        if (!took) begin
            bad++;
            $display("FAIL miss_accept: addr %h not accepted within %0d cycles", a, budget);
        end
    endtask

    int last_done, last_err, last_ready;

    task automatic wait_ready(input int budget);
        bit ok;
        ok         = 1'b0;
        last_done  = -1;
        last_err   = -1;
        last_ready = -1;
        for (int i = 0; i < budget && !ok; i++) begin
            if (miss_ready) ok = 1'b1;
            else begin
                tick();
                if (fill_done) last_done = cyc;
                if (err_timeout) last_err = cyc;
            end
        end
        if (ok) last_ready = cyc;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL wait_ready: miss_ready still 0 after %0d cycles", budget);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc, acc2, nf;
        logic [31:0] exp_wrap [W];
        rst = 1'b1; miss_valid = 1'b0; miss_addr = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        tick();
        chk1("reset_miss_ready", miss_ready, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk1("post_reset_miss_ready", miss_ready, 1'b1);

        // aligned miss, best-case latency
        clear_logs();
        cfg_seq = 1'b1;
        do_miss(32'h1FFFFF10, 20, acc);
        wait_ready(40);
        chk32("aligned_nreq", 32'(req_log.size()), 32'd4);
        chk32("aligned_nfill", 32'(fill_a.size()), 32'd4);
        for (int i = 0; i < 4 && i < req_log.size() && i < fill_a.size(); i++) begin
            chk32("aligned_req_addr", req_log[i], 32'h1FFFFF10 + 32'(4 * i));
            chk32("aligned_fill_addr", fill_a[i], 32'h1FFFFF10 + 32'(4 * i));
            chk32("aligned_fill_data", fill_d[i], 32'hA0 + 32'(i));
            chk1("aligned_fill_last", fill_l[i], i == 3);
        end
        chk32("aligned_done_latency", 32'(last_done - acc), 32'd9);
        chk32("aligned_ready_latency", 32'(last_ready - acc), 32'd10);

        // critical word first with wrap-around
        clear_logs();
        exp_wrap = '{32'h1FFFFF18, 32'h1FFFFF1C, 32'h1FFFFF10, 32'h1FFFFF14};
        do_miss(32'h1FFFFF1A, 20, acc);
        wait_ready(40);
        chk32("wrap_nreq", 32'(req_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < req_log.size(); i++) chk32("wrap_req_addr", req_log[i], exp_wrap[i]);

        // request backpressure on word 1
        clear_logs();
        cfg_stall_hs  = 1;
        cfg_stall_len = 5;
        do_miss(32'h00001230, 20, acc);
        wait_ready(60);
        chk32("bp_stall_cycles", 32'(stall_addr.size()), 32'd5);
        for (int i = 0; i < stall_addr.size(); i++) chk32("bp_stall_addr", stall_addr[i], 32'h00001234);
        chk32("bp_nfill", 32'(fill_a.size()), 32'd4);
        chk32("bp_ndone", 32'(done_cyc.size()), 32'd1);

        // memory never answers word 0
        clear_logs();
        cfg_drop = 1'b1;
        do_miss(32'h00000080, 20, acc);
        wait_ready(150);
        chk32("tmo_nhs", 32'(hs_cyc.size()), 32'd1);
        if (hs_cyc.size() > 0) chk32("tmo_delay", 32'(last_err - hs_cyc[0]), 32'd64);
        chk32("tmo_ready_after_err", 32'(last_ready - last_err), 32'd1);
        chk32("tmo_no_done", 32'(done_cyc.size()), 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEADBEEF;
        tick();
        tick();
        chk32("tmo_stray_ignored", 32'(fill_a.size()), 32'd0);

        // reset in the middle of a refill
        clear_logs();
        nf = 0;
        do_miss(32'h00000300, 20, acc);
        for (int i = 0; i < 40 && nf < 2; i++) begin
            tick();
            if (fill_valid) nf++;
        end
        chk32("mid_rst_fills_before", 32'(nf), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("mid_rst_req_valid", mem_req_valid, 1'b0);
        chk1("mid_rst_fill_valid", fill_valid, 1'b0);
        chk1("mid_rst_miss_ready", miss_ready, 1'b0);
        wait_ready(10);
        clear_logs();
        do_miss(32'h00000040, 20, acc);
        wait_ready(40);
        chk32("post_rst_nreq", 32'(req_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < req_log.size(); i++) chk32("post_rst_req_addr", req_log[i], 32'h40 + 32'(4 * i));
        chk32("post_rst_ndone", 32'(done_cyc.size()), 32'd1);

        // second miss held while the first block is in flight
        clear_logs();
        do_miss(32'h00000500, 20, acc);
        do_miss(32'h00000600, 60, acc2);
        wait_ready(40);
        chk32("busy_accepts", 32'(acc_cnt), 32'd2);
        chk32("busy_ndone", 32'(done_cyc.size()), 32'd2);
        if (done_cyc.size() > 0) chk32("busy_accept_time", 32'(acc2 - done_cyc[0]), 32'd2);
        if (req_log.size() > 4) chk32("busy_second_base", req_log[4], 32'h00000600);

        // random traffic: random ready/latency, strays, drops, resets
        cfg_seq  = 1'b0;
        cfg_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            for (int g = int'($urandom_range(0, 3)); g > 0; g--) tick();
            if ($urandom_range(0, 14) == 0) cfg_drop = 1'b1;
            do_miss($urandom, 300, acc);
            if ($urandom_range(0, 3) == 0) wait_ready(300);
            if ($urandom_range(0, 11) == 0) begin
                for (int g = int'($urandom_range(0, 15)); g > 0; g--) tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
                cfg_drop = 1'b0;
            end
        end
        wait_ready(300);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
